traffic_phase_scheduler: RTL and testbench

// Demand-actuated phase scheduler for the 4-approach intersection (left, right, straight, back).

---
 rtl/traffic_pkg.sv | 38 +++
 rtl/traffic_tick_gen.sv | 28 ++
 rtl/traffic_phase_scheduler.sv | 147 ++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared encodings and helpers for the four-approach phase scheduler.
package traffic_pkg;

    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_RED    = 3'b100;

    localparam logic [1:0] APP_L = 2'd0;
    localparam logic [1:0] APP_R = 2'd1;
    localparam logic [1:0] APP_S = 2'd2;
    localparam logic [1:0] APP_B = 2'd3;

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'd0,
        ST_GREEN   = 2'd1,
        ST_YELLOW  = 2'd2
    } state_e;

    // Round-robin pick: first demand after 'last', wrapping back to 'last'
    // itself; with no demand at all, simply advance to the next approach.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] cand;
        rr_pick = last + 2'd1;
        for (int k = 4; k >= 1; k--) begin
            cand = last + 2'(k);
            if (req[cand]) rr_pick = cand;
        end
    endfunction

    // Lowest-index set bit; only meaningful when v != 0.
    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        lowest_set = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (v[k]) lowest_set = 2'(k);
        end
    endfunction

endpackage

// File: rtl/traffic_tick_gen.sv
// Timing-tick prescaler: one-cycle pulse every CLK_DIV clocks.
module traffic_tick_gen #(
    parameter int CLK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count 0..CLK_DIV-1 and wrap; the tick is the terminal count.
    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated phase scheduler with min/max green, clearance and
// emergency preemption. Lamps are a pure decode of registered state.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_ALL_RED | every approach red; picks the next phase when clearance ends
// ST_GREEN   | approach 'phase' green; holds until preempted, gap- or max-out
// ST_YELLOW  | approach 'phase' yellow for the full clearance, never shortened
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int CLK_DIV   = 100_000_000,
    parameter int TW        = 8,
    parameter int MIN_GREEN = 5,
    parameter int MAX_GREEN = 20,
    parameter int YELLOW    = 3,
    parameter int ALL_RED   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] emg_req,
    output logic [2:0] l,
    output logic [2:0] r,
    output logic [2:0] s,
    output logic [2:0] b,
    output logic [1:0] phase,
    output logic       emg_active
);
    localparam logic [TW-1:0] T_SAT     = {TW{1'b1}};
    localparam logic [TW-1:0] T_MIN_G   = TW'(MIN_GREEN);
    localparam logic [TW-1:0] T_MAX_G   = TW'(MAX_GREEN);
    localparam logic [TW-1:0] T_YELLOW  = TW'(YELLOW);
    localparam logic [TW-1:0] T_ALL_RED = TW'(ALL_RED);

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    phase_q, phase_d;
    logic          emg_q, emg_d;
    logic          tick;
    logic          leave;
    logic [3:0]    phase_mask;
    logic [3:0]    other_req;
    logic [3:0]    other_emg;
    logic [2:0]    lamp_on;

    traffic_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign phase_mask = 4'b0001 << phase_q;
    assign other_req  = req & ~phase_mask;
    assign other_emg  = emg_req & ~phase_mask;

    // Next-state, phase selection and timer update.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        emg_d   = emg_q;
        leave   = 1'b0;
        case (state_q)
            ST_ALL_RED: begin
                if (timer_q >= T_ALL_RED) begin
                    state_d = ST_GREEN;
                    leave   = 1'b1;
                    if (|emg_req) begin
                        phase_d = lowest_set(emg_req);
                        emg_d   = 1'b1;
                    end else begin
                        phase_d = rr_pick(req, phase_q);
                        emg_d   = 1'b0;
                    end
                end
            end
            ST_GREEN: begin
                // Emergency on our own approach pins the green; once it drops
                // the flag clears and normal gap/max rules resume next cycle
                // against the still-running timer.
                if (emg_q && !emg_req[phase_q]) emg_d = 1'b0;
                if (!emg_req[phase_q]) begin
                    if (|other_emg)
                        leave = 1'b1;
                    else if (!emg_q && timer_q >= T_MIN_G && !req[phase_q] && |other_req)
                        leave = 1'b1;
                    else if (!emg_q && timer_q >= T_MAX_G && |other_req)
                        leave = 1'b1;
                end
                if (leave) state_d = ST_YELLOW;
            end
            ST_YELLOW: begin
                if (timer_q >= T_YELLOW) begin
                    state_d = ST_ALL_RED;
                    leave   = 1'b1;
                end
            end
            default: begin
                state_d = ST_ALL_RED;
                leave   = 1'b1;
            end
        endcase
        if (leave)
            timer_d = '0;
        else if (tick && timer_q != T_SAT)
            timer_d = timer_q + TW'(1);
        else
            timer_d = timer_q;
    end

    // State, timer, phase and preemption-flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ALL_RED;
            timer_q <= '0;
            phase_q <= APP_B;
            emg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            phase_q <= phase_d;
            emg_q   <= emg_d;
        end
    end

    // Moore lamp decode from registered state and phase only.
    always_comb begin
        lamp_on = (state_q == ST_GREEN) ? LAMP_GREEN : LAMP_YELLOW;
        l = LAMP_RED;
        r = LAMP_RED;
        s = LAMP_RED;
        b = LAMP_RED;
        if (state_q == ST_GREEN || state_q == ST_YELLOW) begin
            case (phase_q)
                APP_L:   l = lamp_on;
                APP_R:   r = lamp_on;
                APP_S:   s = lamp_on;
                APP_B:   b = lamp_on;
                default: l = LAMP_RED;
            endcase
        end
    end

    assign phase      = phase_q;
    assign emg_active = emg_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler with a 4-clock tick.
module tb_traffic_phase_scheduler;

    localparam logic [2:0] G  = 3'b001;
    localparam logic [2:0] Y  = 3'b010;
    localparam logic [2:0] RD = 3'b100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] emg_req = 4'b0000;
    logic [2:0] l, r, s, b;
    logic [1:0] phase;
    logic       emg_active;
    logic [11:0] obs;

    int n_cmp = 0;
    int n_bad = 0;

    traffic_phase_scheduler #(.CLK_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .emg_req    (emg_req),
        .l          (l),
        .r          (r),
        .s          (s),
        .b          (b),
        .phase      (phase),
        .emg_active (emg_active)
    );

    always #5 clk = ~clk;

    assign obs = {l, r, s, b};

    typedef struct {
        logic [3:0] req;
        logic [3:0] emg;
        int         dly;
        int         g_len;
        int         y_len;
        int         ar_len;
        logic [1:0] nxt;
        logic       nxt_emg;
    } vec_t;

    vec_t tbl [6];

    function automatic logic [11:0] lamps(input logic [1:0] p, input logic [2:0] kind);
        logic [11:0] v;
        v = {4{RD}};
        v[11 - 3*int'(p) -: 3] = kind;
        return v;
    endfunction

    task automatic chk_v(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %03h required %03h", name, act, exp);
        end
    endtask

    task automatic chk_n(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // Counts negedge samples while the lamp vector keeps its current value.
    task automatic measure(output int n);
        logic [11:0] v;
        v = obs;
        n = 0;
        while (obs == v && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req     = 4'b0000;
        emg_req = 4'b0000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Safety invariant: at most one approach non-red, only legal encodings.
    always @(negedge clk) begin
        if (rst_n) begin
            int nonred;
            logic legal;
            nonred = 0;
            legal  = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (obs[11-3*k -: 3] != RD) nonred++;
                if (obs[11-3*k -: 3] != RD && obs[11-3*k -: 3] != G && obs[11-3*k -: 3] != Y)
                    legal = 1'b0;
            end
            n_cmp++;
            if (nonred > 1 || !legal) begin
                n_bad++;
                $display("FAIL lamp_invariant: actual %03h required one non-red legal lamp", obs);
            end
        end
    end

    initial begin
        int n, gl, bad;

        tbl[0] = '{4'b1000, 4'b0000, 0, 20, 12, 4, 2'd3, 1'b0};
        tbl[1] = '{4'b0011, 4'b0000, 0, 80, 12, 4, 2'd1, 1'b0};
        tbl[2] = '{4'b0010, 4'b0000, 0, 20, 12, 4, 2'd1, 1'b0};
        tbl[3] = '{4'b0100, 4'b0000, 0, 20, 12, 4, 2'd2, 1'b0};
        tbl[4] = '{4'b0000, 4'b0100, 7,  8, 12, 4, 2'd2, 1'b1};
        tbl[5] = '{4'b1001, 4'b0110, 0,  1, 11, 4, 2'd1, 1'b1};

        // Reset state, first green on approach 0, idle hold.
        @(negedge clk);
        chk_v("rst_lamps", obs, {4{RD}});
        chk_v("rst_phase", {10'b0, phase}, 12'd3);
        chk_v("rst_emg", {11'b0, emg_active}, 12'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        measure(n);
        chk_n("first_all_red_len", n, 5);
        chk_v("first_green", obs, lamps(2'd0, G));
        chk_v("first_phase", {10'b0, phase}, 12'd0);
        bad = 0;
        repeat (200) begin
            if (obs != lamps(2'd0, G)) bad++;
            @(negedge clk);
        end
        chk_n("idle_hold_breaks", bad, 0);

        // Table: inputs applied dly clocks into green on approach 0.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            measure(n);
            chk_v($sformatf("v%0d_start", i), obs, lamps(2'd0, G));
            gl = 0;
            repeat (tbl[i].dly) begin
                gl++;
                @(negedge clk);
            end
            req     = tbl[i].req;
            emg_req = tbl[i].emg;
            measure(n);
            gl += n;
            chk_n($sformatf("v%0d_green_len", i), gl, tbl[i].g_len);
            chk_v($sformatf("v%0d_yellow", i), obs, lamps(2'd0, Y));
            measure(n);
            chk_n($sformatf("v%0d_yellow_len", i), n, tbl[i].y_len);
            chk_v($sformatf("v%0d_all_red", i), obs, {4{RD}});
            measure(n);
            chk_n($sformatf("v%0d_all_red_len", i), n, tbl[i].ar_len);
            chk_v($sformatf("v%0d_next", i), obs, lamps(tbl[i].nxt, G));
            chk_v($sformatf("v%0d_phase", i), {10'b0, phase}, {10'b0, tbl[i].nxt});
            chk_v($sformatf("v%0d_emg", i), {11'b0, emg_active}, {11'b0, tbl[i].nxt_emg});
        end

        // Emergency green holds past max green, then releases.
        do_reset();
        measure(n);
        emg_req = 4'b0100;
        req     = 4'b0001;
        measure(n);
        measure(n);
        measure(n);
        chk_v("emg_green", obs, lamps(2'd2, G));
        chk_v("emg_flag", {11'b0, emg_active}, 12'd1);
        bad = 0;
        repeat (400) begin
            if (obs != lamps(2'd2, G)) bad++;
            @(negedge clk);
        end
        chk_n("emg_hold_breaks", bad, 0);
        emg_req = 4'b0000;
        @(negedge clk);
        chk_v("emg_drop_flag", {11'b0, emg_active}, 12'd0);
        chk_v("emg_drop_still_green", obs, lamps(2'd2, G));
        @(negedge clk);
        chk_v("emg_drop_yellow", obs, lamps(2'd2, Y));

        // Emergency arriving during all-red wins over round-robin demand.
        do_reset();
        measure(n);
        req = 4'b1000;
        measure(n);
        measure(n);
        chk_v("ar_emg_in_all_red", obs, {4{RD}});
        emg_req = 4'b0110;
        req     = 4'b1001;
        measure(n);
        chk_v("ar_emg_lamps", obs, lamps(2'd1, G));
        chk_v("ar_emg_phase", {10'b0, phase}, 12'd1);
        chk_v("ar_emg_flag", {11'b0, emg_active}, 12'd1);

        // Asynchronous reset between clock edges during yellow.
        do_reset();
        measure(n);
        req = 4'b1000;
        measure(n);
        chk_v("async_pre_yellow", obs, lamps(2'd0, Y));
        #2 rst_n = 1'b0;
        #1;
        chk_v("async_lamps", obs, {4{RD}});
        chk_v("async_phase", {10'b0, phase}, 12'd3);
        chk_v("async_emg", {11'b0, emg_active}, 12'd0);
        req = 4'b0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        measure(n);
        chk_n("async_restart_len", n, 5);
        chk_v("async_restart_green", obs, lamps(2'd0, G));

        // Long green with only own demand: timer must saturate, not wrap.
        do_reset();
        measure(n);
        req = 4'b0001;
        bad = 0;
        repeat (1080) begin
            if (obs != lamps(2'd0, G)) bad++;
            @(negedge clk);
        end
        chk_n("sat_hold_breaks", bad, 0);
        req = 4'b0011;
        @(negedge clk);
        chk_v("sat_maxout_yellow", obs, lamps(2'd0, Y));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
